// File: rtl/axi_lite_obi_bridge.sv
// AXI4-Lite slave to OBI master bridge: one transaction in flight, fair read/write
// arbitration, address-window decode, bus-hang timeout and a saturating error counter.
module axi_lite_obi_bridge #(
  parameter int unsigned              ADDR_WIDTH     = 32,
  parameter int unsigned              DATA_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR      = '0,
  parameter logic [ADDR_WIDTH-1:0]    ADDR_MASK      = '1,
  parameter int unsigned              TIMEOUT_CYCLES = 256,
  parameter int unsigned              ERRCNT_WIDTH   = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [2:0]                s_axi_awprot,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [2:0]                s_axi_arprot,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic                      obi_req_o,
  input  logic                      obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]     obi_addr_o,
  output logic                      obi_we_o,
  output logic [DATA_WIDTH/8-1:0]   obi_be_o,
  output logic [DATA_WIDTH-1:0]     obi_wdata_o,
  input  logic                      obi_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     obi_rdata_i,
  output logic                      busy_o,
  output logic [ERRCNT_WIDTH-1:0]   err_count_o
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);
  localparam int unsigned TCNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCNT_WIDTH-1:0] TCNT_LAST = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StObiReq, StObiRsp, StAxiR, StAxiB} state_e;

  state_e                  state_q;
  logic                    last_grant_q;  // 1: last contest went to the write
  logic                    awready_q, wready_q, arready_q;
  logic                    bvalid_q, rvalid_q, obi_req_q, we_q, busy_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q, wdata_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [STRB_WIDTH-1:0]   be_q;
  logic [TCNT_WIDTH-1:0]   tcnt_q;
  logic [ERRCNT_WIDTH-1:0] err_count_q;

  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [ADDR_WIDTH-1:0]   aligned_addr;
  logic [ERRCNT_WIDTH-1:0] err_count_inc;
  logic                    hit, timeout, write_cand, read_cand, unused_prot;

  assign unused_prot   = ^{s_axi_awprot, s_axi_arprot};
  assign sel_addr      = awready_q ? s_axi_awaddr : s_axi_araddr;
  assign aligned_addr  = {sel_addr[ADDR_WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
  assign hit           = (sel_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  assign timeout       = (TIMEOUT_CYCLES != 0) && (tcnt_q >= TCNT_LAST);
  assign err_count_inc = (err_count_q == '1) ? err_count_q : err_count_q + ERRCNT_WIDTH'(1);
  assign write_cand    = s_axi_awvalid && s_axi_wvalid;
  assign read_cand     = s_axi_arvalid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      arready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      obi_req_q    <= 1'b0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      bresp_q      <= 2'b00;
      rresp_q      <= 2'b00;
      rdata_q      <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      be_q         <= '0;
      tcnt_q       <= '0;
      err_count_q  <= '0;
    end else begin
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (awready_q || arready_q) begin
            // Handshake cycle: channel inputs are still valid, latch and decode them.
            we_q    <= awready_q;
            addr_q  <= aligned_addr;
            wdata_q <= awready_q ? s_axi_wdata : '0;
            be_q    <= awready_q ? s_axi_wstrb : '1;
            tcnt_q  <= '0;
            busy_q  <= 1'b1;
            if (!hit) begin
              err_count_q <= err_count_inc;
              if (awready_q) begin
                state_q  <= StAxiB;
                bvalid_q <= 1'b1;
                bresp_q  <= 2'b11;
              end else begin
                state_q  <= StAxiR;
                rvalid_q <= 1'b1;
                rdata_q  <= '0;
                rresp_q  <= 2'b11;
              end
            end else if (awready_q && (s_axi_wstrb == '0)) begin
              state_q  <= StAxiB;
              bvalid_q <= 1'b1;
              bresp_q  <= 2'b00;
            end else begin
              state_q   <= StObiReq;
              obi_req_q <= 1'b1;
            end
          end else if (write_cand && (!read_cand || !last_grant_q)) begin
            awready_q    <= 1'b1;
            wready_q     <= 1'b1;
            last_grant_q <= 1'b1;
          end else if (read_cand) begin
            arready_q    <= 1'b1;
            last_grant_q <= 1'b0;
          end
        end
        StObiReq, StObiRsp: begin
          if (state_q == StObiReq && obi_gnt_i) begin
            obi_req_q <= 1'b0;
            state_q   <= StObiRsp;
            tcnt_q    <= tcnt_q + TCNT_WIDTH'(1);
          end else if (state_q == StObiRsp && obi_rvalid_i) begin
            if (we_q) begin
              state_q  <= StAxiB;
              bvalid_q <= 1'b1;
              bresp_q  <= 2'b00;
            end else begin
              state_q  <= StAxiR;
              rvalid_q <= 1'b1;
              rdata_q  <= obi_rdata_i;
              rresp_q  <= 2'b00;
            end
          end else if (timeout) begin
            // Hung slave: abandon the request and answer SLVERR.
            obi_req_q   <= 1'b0;
            err_count_q <= err_count_inc;
            if (we_q) begin
              state_q  <= StAxiB;
              bvalid_q <= 1'b1;
              bresp_q  <= 2'b10;
            end else begin
              state_q  <= StAxiR;
              rvalid_q <= 1'b1;
              rdata_q  <= '0;
              rresp_q  <= 2'b10;
            end
          end else begin
            tcnt_q <= tcnt_q + TCNT_WIDTH'(1);
          end
        end
        StAxiR: begin
          if (s_axi_rready) begin
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StAxiB: begin
          if (s_axi_bready) begin
            bvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_arready = arready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign obi_req_o     = obi_req_q;
  assign obi_addr_o    = addr_q;
  assign obi_we_o      = we_q;
  assign obi_be_o      = be_q;
  assign obi_wdata_o   = wdata_q;
  assign busy_o        = busy_q;
  assign err_count_o   = err_count_q;

endmodule
